// File: rtl/user_clock_lock_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : user_clock_lock_monitor_if
//  Description : Bundles the lock-monitor signals that sit between the PLL
//                environment and the monitor.
//                  locked_in       - PLL lock indication, asynchronous to clk
//                  pll_rst_out     - active-high reset to the PLL
//                  rst_n_out       - active-low reset for user-clock logic
//                  fail_out        - sticky: lock could not be achieved
//                  lock_loss_count - saturating count of lock losses in RUN
//                master : environment side (drives locked_in)
//                slave  : monitor side (drives the outputs)
//  Revision    : 1.0  initial release
// ============================================================================
interface user_clock_lock_monitor_if;
    logic       locked_in;
    logic       pll_rst_out;
    logic       rst_n_out;
    logic       fail_out;
    logic [7:0] lock_loss_count;

    modport master (
        output locked_in,
        input  pll_rst_out,
        input  rst_n_out,
        input  fail_out,
        input  lock_loss_count
    );

    modport slave (
        input  locked_in,
        output pll_rst_out,
        output rst_n_out,
        output fail_out,
        output lock_loss_count
    );
endinterface
`default_nettype wire

// File: rtl/user_clock_lock_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : user_clock_lock_monitor
//  Description : Sequences a PLL through reset, waits for lock, requires a
//                stable lock period before releasing the user reset, and
//                restarts the PLL on lock loss. Repeated lock timeouts end in
//                a sticky FAIL state that only rst clears.
//  Ports       : clk  - PLL reference clock (single clock domain)
//                rst  - synchronous active-high reset
//                bus  - user_clock_lock_monitor_if.slave
//                       (locked_in in; pll_rst_out, rst_n_out, fail_out,
//                        lock_loss_count out)
//  Revision    : 1.0  initial release
// ============================================================================
module user_clock_lock_monitor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    user_clock_lock_monitor_if.slave     bus
);

    localparam int c_cnt_w = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int c_ret_w = $clog2(MAX_RETRIES + 1);

    // Terminal counts: each phase leaves on the edge where the counter
    // already holds N-1, so the phase lasts exactly N cycles.
    localparam logic [c_cnt_w-1:0] c_pll_last     = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_ret_w-1:0] c_retry_last   = c_ret_w'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_ret_w-1:0]   r_retries;
    logic [7:0]           r_loss_count;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_pll_rst;
    logic                 r_rst_n;
    logic                 r_fail;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.locked_in;
            r_sync2 <= r_sync1;
        end
    end

    // Outputs are updated together with the state on every transition so
    // each one is a flop that mirrors exactly one state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_PLL_RESET;
            r_cnt        <= '0;
            r_retries    <= '0;
            r_loss_count <= '0;
            r_pll_rst    <= 1'b1;
            r_rst_n      <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            case (r_state)
                S_PLL_RESET: begin
                    if (r_cnt == c_pll_last) begin
                        r_state   <= S_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    // Lock is tested first so it wins over a coincident timeout.
                    if (r_sync2) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_timeout_last) begin
                        r_cnt <= '0;
                        if (r_retries == c_retry_last) begin
                            r_state <= S_FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state   <= S_PLL_RESET;
                            r_retries <= r_retries + 1'b1;
                            r_pll_rst <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_STABLE: begin
                    if (!r_sync2) begin
                        // Chatter: restart the wait without consuming a retry.
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_stable_last) begin
                        r_state   <= S_RUN;
                        r_cnt     <= '0;
                        r_retries <= '0;
                        r_rst_n   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    if (!r_sync2) begin
                        r_state   <= S_PLL_RESET;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        r_rst_n   <= 1'b0;
                        if (r_loss_count != 8'hFF) begin
                            r_loss_count <= r_loss_count + 8'd1;
                        end
                    end
                end

                S_FAIL: begin
                    // Terminal until rst.
                end

                default: begin
                    // Unreachable encodings recover through a fresh PLL reset.
                    r_state   <= S_PLL_RESET;
                    r_cnt     <= '0;
                    r_pll_rst <= 1'b1;
                    r_rst_n   <= 1'b0;
                    r_fail    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst_out     = r_pll_rst;
    assign bus.rst_n_out       = r_rst_n;
    assign bus.fail_out        = r_fail;
    assign bus.lock_loss_count = r_loss_count;

endmodule
`default_nettype wire

// File: tb/tb_user_clock_lock_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_user_clock_lock_monitor
//  Description : Directed bench for user_clock_lock_monitor with
//                PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8,
//                LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2. Inputs change 1 ns
//                after a rising edge; outputs are sampled at that same point.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_user_clock_lock_monitor;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    user_clock_lock_monitor_if bus ();

    user_clock_lock_monitor #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called while in WAIT_LOCK: lock reaches the FSM on the 3rd edge
    // (STABLE entry), user reset releases 8 edges after that.
    task automatic lock_up_to_run(input string tag);
        bus.locked_in = 1'b1;
        step(10);
        chk({tag, "_rstn_before"}, {7'd0, bus.rst_n_out}, 8'd0);
        step(1);
        chk({tag, "_rstn_release"}, {7'd0, bus.rst_n_out}, 8'd1);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.locked_in = 1'b0;

        // Reset state
        step(3);
        chk("rst_pll",  {7'd0, bus.pll_rst_out}, 8'd1);
        chk("rst_rstn", {7'd0, bus.rst_n_out},   8'd0);
        chk("rst_fail", {7'd0, bus.fail_out},    8'd0);
        chk("rst_loss", bus.lock_loss_count,     8'd0);

        // Clean start: 4-cycle PLL reset, lock raised 10 cycles after release
        rst = 1'b0;
        step(3);
        chk("start_pll_hold", {7'd0, bus.pll_rst_out}, 8'd1);
        step(1);
        chk("start_pll_drop", {7'd0, bus.pll_rst_out}, 8'd0);
        step(6);
        lock_up_to_run("start");
        chk("start_loss", bus.lock_loss_count, 8'd0);

        // Lock loss in RUN: reaction on the 3rd edge
        bus.locked_in = 1'b0;
        step(2);
        chk("loss_rstn_edge2", {7'd0, bus.rst_n_out}, 8'd1);
        step(1);
        chk("loss_rstn_edge3", {7'd0, bus.rst_n_out},   8'd0);
        chk("loss_pll_edge3",  {7'd0, bus.pll_rst_out}, 8'd1);
        chk("loss_count1",     bus.lock_loss_count,     8'd1);
        step(3);
        chk("loss_pll_hold", {7'd0, bus.pll_rst_out}, 8'd1);
        step(1);
        chk("loss_pll_drop", {7'd0, bus.pll_rst_out}, 8'd0);
        lock_up_to_run("relock");

        // Chatter during STABLE: the 8-cycle count must restart
        bus.locked_in = 1'b0;
        step(7);
        bus.locked_in = 1'b1;
        step(5);
        bus.locked_in = 1'b0;
        step(2);
        bus.locked_in = 1'b1;
        step(4);
        chk("chatter_no_early_run", {7'd0, bus.rst_n_out}, 8'd0);
        step(6);
        chk("chatter_rstn_before",  {7'd0, bus.rst_n_out}, 8'd0);
        step(1);
        chk("chatter_rstn_release", {7'd0, bus.rst_n_out}, 8'd1);
        chk("chatter_loss",         bus.lock_loss_count,   8'd2);

        // Reset mid-RUN with lock held
        rst = 1'b1;
        step(1);
        chk("midrst_rstn", {7'd0, bus.rst_n_out},   8'd0);
        chk("midrst_pll",  {7'd0, bus.pll_rst_out}, 8'd1);
        chk("midrst_loss", bus.lock_loss_count,     8'd0);
        rst = 1'b0;
        step(3);
        chk("midrst_pll_hold", {7'd0, bus.pll_rst_out}, 8'd1);
        step(1);
        chk("midrst_pll_drop", {7'd0, bus.pll_rst_out}, 8'd0);
        step(8);
        chk("midrst_rstn_before",  {7'd0, bus.rst_n_out}, 8'd0);
        step(1);
        chk("midrst_rstn_release", {7'd0, bus.rst_n_out}, 8'd1);

        // Saturation over 260 loss/relock cycles
        for (int i = 1; i <= 260; i++) begin
            bus.locked_in = 1'b0;
            step(3);
            chk("sat_loss", bus.lock_loss_count, (i > 255) ? 8'd255 : 8'(i));
            step(4);
            lock_up_to_run("sat");
        end

        // Timeout path to FAIL with lock held low
        bus.locked_in = 1'b0;
        step(3);
        chk("fail_loss_no_wrap", bus.lock_loss_count,     8'd255);
        chk("fail_pll_first",    {7'd0, bus.pll_rst_out}, 8'd1);
        step(4);
        step(31);
        chk("fail_wait1_end",  {7'd0, bus.pll_rst_out}, 8'd0);
        step(1);
        chk("fail_retry_pll",  {7'd0, bus.pll_rst_out}, 8'd1);
        step(3);
        chk("fail_retry_hold", {7'd0, bus.pll_rst_out}, 8'd1);
        step(1);
        chk("fail_retry_drop", {7'd0, bus.pll_rst_out}, 8'd0);
        step(31);
        chk("fail_not_yet", {7'd0, bus.fail_out},    8'd0);
        step(1);
        chk("fail_set",     {7'd0, bus.fail_out},    8'd1);
        chk("fail_pll",     {7'd0, bus.pll_rst_out}, 8'd0);
        chk("fail_rstn",    {7'd0, bus.rst_n_out},   8'd0);
        bus.locked_in = 1'b1;
        step(50);
        chk("fail_sticky",      {7'd0, bus.fail_out},    8'd1);
        chk("fail_sticky_pll",  {7'd0, bus.pll_rst_out}, 8'd0);
        chk("fail_sticky_rstn", {7'd0, bus.rst_n_out},   8'd0);

        // Reset out of FAIL
        rst           = 1'b1;
        bus.locked_in = 1'b0;
        step(1);
        chk("failrst_fail", {7'd0, bus.fail_out},    8'd0);
        chk("failrst_pll",  {7'd0, bus.pll_rst_out}, 8'd1);
        chk("failrst_loss", bus.lock_loss_count,     8'd0);

        // Lock arriving on the timeout cycle wins
        rst = 1'b0;
        step(33);
        bus.locked_in = 1'b1;
        step(2);
        chk("race_pll_before", {7'd0, bus.pll_rst_out}, 8'd0);
        step(1);
        chk("race_lock_wins",  {7'd0, bus.pll_rst_out}, 8'd0);
        step(7);
        chk("race_rstn_before",  {7'd0, bus.rst_n_out}, 8'd0);
        step(1);
        chk("race_rstn_release", {7'd0, bus.rst_n_out}, 8'd1);

        // Sub-period lock pulse spanning one edge: no RUN entry
        rst           = 1'b1;
        bus.locked_in = 1'b0;
        step(1);
        rst = 1'b0;
        step(4);
        #7;
        bus.locked_in = 1'b1;
        #4;
        bus.locked_in = 1'b0;
        step(1);
        step(12);
        chk("pulse_rstn", {7'd0, bus.rst_n_out},   8'd0);
        chk("pulse_pll",  {7'd0, bus.pll_rst_out}, 8'd0);
        chk("pulse_fail", {7'd0, bus.fail_out},    8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
